// File: rtl/gshare_pht_if.sv
// Fetch-side predict and resolve-side update bundle for the gshare pattern history table.
interface gshare_pht_if #(
    parameter int N = 9
);
    logic          pred_valid;
    logic [31:0]   pred_pc;
    logic [N-1:0]  pred_ghr;
    logic          pred_ready;
    logic          pred_out_valid;
    logic          pred_taken;
    logic [N-1:0]  pred_index;
    logic          upd_valid;
    logic [N-1:0]  upd_index;
    logic          upd_taken;

    modport master (
        output pred_valid, pred_pc, pred_ghr, upd_valid, upd_index, upd_taken,
        input  pred_ready, pred_out_valid, pred_taken, pred_index
    );

    modport slave (
        input  pred_valid, pred_pc, pred_ghr, upd_valid, upd_index, upd_taken,
        output pred_ready, pred_out_valid, pred_taken, pred_index
    );
endinterface

// File: rtl/gshare_pht.sv
// Gshare PHT: PC ^ history indexes a table of saturating counters; one-cycle registered
// prediction, single-cycle read-modify-write training, self-clearing init sweep after reset.
module gshare_pht #(
    parameter int N     = 9,
    parameter int CTR_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    gshare_pht_if.slave  bus
);
    localparam int               DEPTH    = 1 << N;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_ZERO = '0;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1);
    localparam logic [N-1:0]     PTR_LAST = '1;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     init_ptr_q, init_ptr_d;
    logic             ready_q, ready_d;
    logic             out_valid_q, out_valid_d;
    logic             taken_q, taken_d;
    logic [N-1:0]     index_q, index_d;

    logic [CTR_W-1:0] table_q [DEPTH];

    logic [N-1:0]     pred_idx;
    logic [CTR_W-1:0] upd_old, upd_new, pred_ctr;
    logic             upd_en, pred_fire;
    logic             wr_en;
    logic [N-1:0]     wr_addr;
    logic [CTR_W-1:0] wr_data;

    logic unused_pc;
    assign unused_pc = ^{bus.pred_pc[31:N+2], bus.pred_pc[1:0]};

    always_comb begin
        pred_idx  = bus.pred_pc[N+1:2] ^ bus.pred_ghr;
        upd_en    = bus.upd_valid && (state_q == S_READY);
        pred_fire = bus.pred_valid && ready_q;

        upd_old = table_q[bus.upd_index];
        upd_new = upd_old;
        if (bus.upd_taken) begin
            if (upd_old != CTR_MAX) upd_new = upd_old + 1'b1;
        end else begin
            if (upd_old != CTR_ZERO) upd_new = upd_old - 1'b1;
        end

        // Write-first: a same-cycle update to the predicted entry is visible to the prediction.
        pred_ctr = table_q[pred_idx];
        if (upd_en && (bus.upd_index == pred_idx)) pred_ctr = upd_new;
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.upd_index;
        wr_data = upd_new;
        if (state_q == S_INIT) begin
            wr_en   = 1'b1;
            wr_addr = init_ptr_q;
            wr_data = CTR_INIT;
        end else if (upd_en) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) table_q[wr_addr] <= wr_data;
    end

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        out_valid_d = 1'b0;
        taken_d     = taken_q;
        index_d     = index_q;
        case (state_q)
            S_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == PTR_LAST) state_d = S_READY;
            end
            S_READY: begin
                if (pred_fire) begin
                    out_valid_d = 1'b1;
                    taken_d     = pred_ctr[CTR_W-1];
                    index_d     = pred_idx;
                end
            end
            default: state_d = S_INIT;
        endcase
        ready_d = (state_d == S_READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            init_ptr_q  <= '0;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            taken_q     <= taken_d;
            index_q     <= index_d;
        end
    end

    assign bus.pred_ready     = ready_q;
    assign bus.pred_out_valid = out_valid_q;
    assign bus.pred_taken     = taken_q;
    assign bus.pred_index     = index_q;
endmodule

// File: tb/tb_gshare_pht.sv
// Randomized bench for gshare_pht with a table-of-integers reference model.
module tb_gshare_pht;
    localparam int N = 9;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gshare_pht_if #(.N(N)) bus ();
    gshare_pht #(.N(N), .CTR_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vec = 0;
    int bad = 0;

    int         mdl [DEPTH];
    bit         ready_m;
    int         cnt_m;
    bit         e_ov, e_tk;
    logic [8:0] e_idx;

    // One clock of stimulus; the model advances on what the table saw this cycle.
    task automatic cyc(input bit rst_i, input bit pv, input logic [31:0] pc, input logic [8:0] ghr,
                       input bit uv, input logic [8:0] ui, input bit ut);
        logic [8:0] idx;
        reset          = rst_i;
        bus.pred_valid = pv;
        bus.pred_pc    = pc;
        bus.pred_ghr   = ghr;
        bus.upd_valid  = uv;
        bus.upd_index  = ui;
        bus.upd_taken  = ut;
        @(posedge clk);
        if (rst_i) begin
            ready_m = 0; cnt_m = 0; e_ov = 0; e_tk = 0; e_idx = '0;
            for (int i = 0; i < DEPTH; i++) mdl[i] = 1;
        end else if (!ready_m) begin
            e_ov = 0;
            cnt_m++;
            if (cnt_m == DEPTH) ready_m = 1;
        end else begin
            if (uv) begin
                if (ut) mdl[ui] = (mdl[ui] == 3) ? 3 : mdl[ui] + 1;
                else    mdl[ui] = (mdl[ui] == 0) ? 0 : mdl[ui] - 1;
            end
            if (pv) begin
                idx   = pc[10:2] ^ ghr;
                e_ov  = 1;
                e_idx = idx;
                e_tk  = (mdl[idx] >= 2);
            end else begin
                e_ov = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 9'h0, 0, 9'h0, 0);
    endtask

    task automatic test_reset();
        int n;
        bit seen_ov;
        logic [31:0] pc;
        logic [8:0]  ghr, want;
        repeat (3) cyc(1, 1, $urandom, 9'($urandom), 1, 9'($urandom), 1);
        vec++;
        if ({bus.pred_ready, bus.pred_out_valid, bus.pred_taken, bus.pred_index} !== 12'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b tk=%b idx=%0h want all 0",
                     bus.pred_ready, bus.pred_out_valid, bus.pred_taken, bus.pred_index);
        end
        n = 0; seen_ov = 0;
        while (bus.pred_ready !== 1'b1 && n < 2000) begin
            cyc(0, 1, $urandom, 9'($urandom), 0, 9'h0, 0);
            n++;
            if (bus.pred_out_valid !== 1'b0 || bus.pred_index !== 9'h0 || bus.pred_taken !== 1'b0)
                seen_ov = 1;
        end
        vec++;
        if (n != 512) begin
            bad++;
            $display("FAIL sweep_length: got %0d cycles want 512", n);
        end
        vec++;
        if (seen_ov) begin
            bad++;
            $display("FAIL init_outputs_zero: got nonzero output during INIT want 0");
        end
        pc = $urandom; ghr = 9'($urandom);
        want = pc[10:2] ^ ghr;
        cyc(0, 1, pc, ghr, 0, 9'h0, 0);
        vec++;
        if ({bus.pred_out_valid, bus.pred_taken, bus.pred_index} !== {1'b1, 1'b0, want}) begin
            bad++;
            $display("FAIL first_pred: got ov=%b tk=%b idx=%0h want ov=1 tk=0 idx=%0h",
                     bus.pred_out_valid, bus.pred_taken, bus.pred_index, want);
        end
    endtask

    task automatic test_hash();
        cyc(0, 1, 32'h14, 9'h005, 0, 9'h0, 0);
        vec++;
        if (bus.pred_out_valid !== 1'b1 || bus.pred_index !== 9'h000) begin
            bad++;
            $display("FAIL hash_0: got ov=%b idx=%0h want ov=1 idx=0", bus.pred_out_valid, bus.pred_index);
        end
        cyc(0, 1, 32'h14, 9'h000, 0, 9'h0, 0);
        vec++;
        if (bus.pred_index !== 9'h005) begin
            bad++;
            $display("FAIL hash_5: got idx=%0h want 5", bus.pred_index);
        end
        idle();
        vec++;
        if (bus.pred_out_valid !== 1'b0 || bus.pred_index !== 9'h005) begin
            bad++;
            $display("FAIL hold: got ov=%b idx=%0h want ov=0 idx=5", bus.pred_out_valid, bus.pred_index);
        end
    endtask

    task automatic test_saturate();
        bit want [8] = '{1, 1, 0, 0, 0, 0, 0, 1};
        bit dir  [8] = '{1, 0, 0, 0, 0, 0, 1, 1};
        repeat (5) cyc(0, 0, 32'h0, 9'h0, 1, 9'd5, 1);
        cyc(0, 1, 32'h0, 9'd5, 0, 9'h0, 0);
        vec++;
        if (bus.pred_taken !== want[0]) begin
            bad++;
            $display("FAIL sat_high: got %b want %b", bus.pred_taken, want[0]);
        end
        // Step down past zero then back up; a wrap would show up on the way back.
        for (int i = 1; i < 8; i++) begin
            cyc(0, 0, 32'h0, 9'h0, 1, 9'd5, dir[i]);
            cyc(0, 1, 32'h0, 9'd5, 0, 9'h0, 0);
            vec++;
            if (bus.pred_taken !== want[i] || bus.pred_taken !== e_tk) begin
                bad++;
                $display("FAIL sat_step%0d: got %b want %b", i, bus.pred_taken, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc(0, 1, 32'h0, 9'd7, 1, 9'd7, 1);
        vec++;
        if (bus.pred_taken !== 1'b1 || bus.pred_index !== 9'd7) begin
            bad++;
            $display("FAIL bypass: got tk=%b idx=%0h want tk=1 idx=7", bus.pred_taken, bus.pred_index);
        end
        cyc(0, 1, 32'h0, 9'd8, 1, 9'd7, 1);
        vec++;
        if (bus.pred_taken !== 1'b0 || bus.pred_index !== 9'd8) begin
            bad++;
            $display("FAIL diff_index: got tk=%b idx=%0h want tk=0 idx=8", bus.pred_taken, bus.pred_index);
        end
        cyc(0, 0, 32'h0, 9'h0, 1, 9'd7, 0);
        cyc(0, 1, 32'h0, 9'd7, 0, 9'h0, 0);
        vec++;
        if (bus.pred_taken !== 1'b1) begin
            bad++;
            $display("FAIL diff_index_upd: got tk=%b want 1", bus.pred_taken);
        end
        cyc(0, 0, 32'h0, 9'h0, 1, 9'd21, 1);
        cyc(0, 0, 32'h0, 9'h0, 1, 9'd21, 1);
        cyc(0, 0, 32'h0, 9'h0, 1, 9'd21, 0);
        cyc(0, 1, 32'h0, 9'd21, 0, 9'h0, 0);
        vec++;
        if (bus.pred_taken !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accum: got tk=%b want 1", bus.pred_taken);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [8:0]  ghr;
        for (int i = 0; i < 400; i++) begin
            pc  = $urandom;
            ghr = pc[10:2] ^ 9'($urandom_range(0, 15));
            cyc(0, $urandom_range(0, 1) == 1, pc, ghr,
                $urandom_range(0, 2) != 0, 9'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
            vec++;
            if ({bus.pred_out_valid, bus.pred_taken, bus.pred_index} !== {e_ov, e_tk, e_idx}) begin
                bad++;
                $display("FAIL random[%0d]: got ov=%b tk=%b idx=%0h want ov=%b tk=%b idx=%0h", i,
                         bus.pred_out_valid, bus.pred_taken, bus.pred_index, e_ov, e_tk, e_idx);
            end
        end
    endtask

    task automatic test_reset_midsweep();
        int n;
        repeat (3) cyc(0, 0, 32'h0, 9'h0, 1, 9'd3, 1);
        cyc(0, 1, 32'h0, 9'd3, 0, 9'h0, 0);
        vec++;
        if (bus.pred_taken !== 1'b1) begin
            bad++;
            $display("FAIL train_idx3: got tk=%b want 1", bus.pred_taken);
        end
        cyc(1, 0, 32'h0, 9'h0, 0, 9'h0, 0);
        repeat (100) idle();
        vec++;
        if (bus.pred_ready !== 1'b0) begin
            bad++;
            $display("FAIL midsweep_ready: got %b want 0", bus.pred_ready);
        end
        cyc(1, 0, 32'h0, 9'h0, 0, 9'h0, 0);
        n = 0;
        while (bus.pred_ready !== 1'b1 && n < 2000) begin
            cyc(0, 1, 32'h0, 9'd3, 0, 9'h0, 0);
            n++;
        end
        vec++;
        if (n != 512) begin
            bad++;
            $display("FAIL restart_sweep: got %0d cycles want 512", n);
        end
        cyc(0, 1, 32'h0, 9'd3, 0, 9'h0, 0);
        vec++;
        if (bus.pred_out_valid !== 1'b1 || bus.pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL idx3_cleared: got ov=%b tk=%b want ov=1 tk=0", bus.pred_out_valid, bus.pred_taken);
        end
    endtask

    task automatic test_init_update();
        int n;
        cyc(1, 0, 32'h0, 9'h0, 0, 9'h0, 0);
        n = 0;
        while (bus.pred_ready !== 1'b1 && n < 2000) begin
            cyc(0, 0, 32'h0, 9'h0, 1, 9'd9, 1);
            n++;
        end
        vec++;
        if (n != 512) begin
            bad++;
            $display("FAIL init_upd_sweep: got %0d cycles want 512", n);
        end
        cyc(0, 1, 32'h0, 9'd9, 0, 9'h0, 0);
        vec++;
        if (bus.pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL init_upd_ignored: got tk=%b want 0", bus.pred_taken);
        end
        cyc(0, 0, 32'h0, 9'h0, 1, 9'd9, 1);
        cyc(0, 1, 32'h0, 9'd9, 0, 9'h0, 0);
        vec++;
        if (bus.pred_taken !== 1'b1) begin
            bad++;
            $display("FAIL init_upd_one_taken: got tk=%b want 1", bus.pred_taken);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.pred_valid = 0; bus.pred_pc = '0; bus.pred_ghr = '0;
        bus.upd_valid = 0; bus.upd_index = '0; bus.upd_taken = 0;
        test_reset();
        test_hash();
        test_saturate();
        test_back_to_back();
        test_random();
        test_reset_midsweep();
        test_init_update();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
